int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_pkg.sv | 30 +++
 rtl/int_ctrl_if.sv | 29 ++
 rtl/int_ctrl_edge_det.sv | 23 ++
 rtl/int_ctrl.sv | 113 +++++++++++
 tb/tb_int_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_pkg
// Description : Shared cause codes, FSM state encoding and source-select type
//               for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package int_pkg;

    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_CLR = 2'd3
    } state_t;

    typedef enum logic {
        SRC_TIMER = 1'b0,
        SRC_EXT   = 1'b1
    } src_t;

    function automatic logic [3:0] cause_of(input src_t s);
        return (s == SRC_EXT) ? CAUSE_MEI : CAUSE_MTI;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_if
// Description : Source, CPU-enable and CPU-handshake signals of int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface int_ctrl_if;
    logic       timer_int;
    logic       external_int;
    logic       global_ie;
    logic       mie_timer;
    logic       mie_ext;
    logic       cpu_int_ack;
    logic       int_req;
    logic [3:0] int_cause;
    logic       timer_int_ack;
    logic       ext_int_ack;

    modport master (
        output timer_int, external_int, global_ie, mie_timer, mie_ext, cpu_int_ack,
        input  int_req, int_cause, timer_int_ack, ext_int_ack
    );

    modport slave (
        input  timer_int, external_int, global_ie, mie_timer, mie_ext, cpu_int_ack,
        output int_req, int_cause, timer_int_ack, ext_int_ack
    );
endinterface
`default_nettype wire

// File: rtl/int_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_det
// Description : Rising-edge detector; previous sample resets low so a level
//               held through reset release still reports an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic in,
    output logic      rise
);
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= in;
    end

    assign rise = in & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Two-source interrupt controller with pending latches,
//               priority select, CPU handshake and source acknowledge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int unsigned ACK_CYCLES   = 1,
    parameter int unsigned DROP_TIMEOUT = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    int_ctrl_if.slave   bus
);
    import int_pkg::*;

    localparam logic [3:0] c_ACK_LAST  = 4'(ACK_CYCLES - 1);
    localparam logic [7:0] c_WAIT_LAST = 8'(DROP_TIMEOUT - 1);

    logic       w_rise_timer, w_rise_ext;
    logic       r_pend_timer, r_pend_ext;
    logic       w_clr_timer, w_clr_ext;
    state_t     r_state, w_state_nxt;
    src_t       r_served, w_served_nxt;
    logic [3:0] r_ack_cnt, w_ack_cnt_nxt;
    logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
    logic       w_take_timer, w_take_ext, w_srv_en, w_srv_in;
    logic       r_int_req, r_timer_ack, r_ext_ack;
    logic [3:0] r_int_cause;

    edge_det u_edge_timer (.clk(clk), .reset(reset), .in(bus.timer_int),    .rise(w_rise_timer));
    edge_det u_edge_ext   (.clk(clk), .reset(reset), .in(bus.external_int), .rise(w_rise_ext));

    assign w_take_timer = r_pend_timer & bus.mie_timer;
    assign w_take_ext   = r_pend_ext   & bus.mie_ext;
    assign w_srv_en     = (r_served == SRC_EXT) ? bus.mie_ext      : bus.mie_timer;
    assign w_srv_in     = (r_served == SRC_EXT) ? bus.external_int : bus.timer_int;

    always_comb begin
        w_state_nxt    = r_state;
        w_served_nxt   = r_served;
        w_ack_cnt_nxt  = r_ack_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_clr_timer    = 1'b0;
        w_clr_ext      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.global_ie && (w_take_ext || w_take_timer)) begin
                    w_state_nxt  = ST_REQ;
                    w_served_nxt = w_take_ext ? SRC_EXT : SRC_TIMER;
                end
            end
            ST_REQ: begin
                // A trap the CPU already took wins over a same-cycle enable drop.
                if (bus.cpu_int_ack) begin
                    w_state_nxt   = ST_ACK;
                    w_ack_cnt_nxt = c_ACK_LAST;
                    w_clr_ext     = (r_served == SRC_EXT);
                    w_clr_timer   = (r_served == SRC_TIMER);
                end else if (!bus.global_ie || !w_srv_en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (r_ack_cnt == 4'd0) begin
                    w_state_nxt    = ST_WAIT_CLR;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt - 4'd1;
                end
            end
            ST_WAIT_CLR: begin
                if (!w_srv_in || (r_wait_cnt == c_WAIT_LAST)) w_state_nxt = ST_IDLE;
                else                                         w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_served     <= SRC_TIMER;
            r_ack_cnt    <= 4'd0;
            r_wait_cnt   <= 8'd0;
            r_pend_timer <= 1'b0;
            r_pend_ext   <= 1'b0;
            r_int_req    <= 1'b0;
            r_int_cause  <= 4'd0;
            r_timer_ack  <= 1'b0;
            r_ext_ack    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_served     <= w_served_nxt;
            r_ack_cnt    <= w_ack_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            // A fresh edge must never be lost, so set dominates clear.
            r_pend_timer <= w_rise_timer | (r_pend_timer & ~w_clr_timer);
            r_pend_ext   <= w_rise_ext   | (r_pend_ext   & ~w_clr_ext);
            r_int_req    <= (w_state_nxt == ST_REQ);
            r_int_cause  <= (w_state_nxt == ST_REQ) ? cause_of(w_served_nxt) : 4'd0;
            r_timer_ack  <= (w_state_nxt == ST_ACK) && (w_served_nxt == SRC_TIMER);
            r_ext_ack    <= (w_state_nxt == ST_ACK) && (w_served_nxt == SRC_EXT);
        end
    end

    assign bus.int_req       = r_int_req;
    assign bus.int_cause     = r_int_cause;
    assign bus.timer_int_ack = r_timer_ack;
    assign bus.ext_int_ack   = r_ext_ack;
endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Directed self-checking bench for int_ctrl (ACK_CYCLES 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    int_ctrl_if if1 ();
    int_ctrl_if if4 ();

    int_ctrl #(.ACK_CYCLES(1), .DROP_TIMEOUT(16)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    int_ctrl #(.ACK_CYCLES(4), .DROP_TIMEOUT(16)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_if1;
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack  = 1'b0;
        if1.timer_int    = 1'b0;
        if1.external_int = 1'b0;
        step(4);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", if1.int_req); end
        n_vec++; if (if1.int_cause !== 4'd0) begin n_err++; $display("FAIL reset_cause got %0d exp 0", if1.int_cause); end
        n_vec++; if (if1.timer_int_ack !== 1'b0 || if1.ext_int_ack !== 1'b0) begin n_err++; $display("FAIL reset_acks got %b%b exp 00", if1.timer_int_ack, if1.ext_int_ack); end
        n_vec++; if (if4.int_req !== 1'b0) begin n_err++; $display("FAIL reset_req4 got %b exp 0", if4.int_req); end
        reset = 1'b0;
        if1.global_ie = 1'b1; if1.mie_timer = 1'b1; if1.mie_ext = 1'b1;
        if4.global_ie = 1'b1; if4.mie_timer = 1'b1; if4.mie_ext = 1'b1;
        step(2);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL post_reset_req got %b exp 0", if1.int_req); end
    endtask

    task automatic test_timer_basic;
        if1.timer_int = 1'b1;
        step(1);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL tmr_lat1 got %b exp 0", if1.int_req); end
        step(1);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL tmr_req got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        step(2);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL tmr_hold got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack = 1'b0;
        n_vec++; if (if1.timer_int_ack !== 1'b1 || if1.ext_int_ack !== 1'b0) begin n_err++; $display("FAIL tmr_ack got %b%b exp 10", if1.timer_int_ack, if1.ext_int_ack); end
        n_vec++; if (if1.int_req !== 1'b0 || if1.int_cause !== 4'd0) begin n_err++; $display("FAIL tmr_req_off got %b/%0d exp 0/0", if1.int_req, if1.int_cause); end
        step(1);
        n_vec++; if (if1.timer_int_ack !== 1'b0) begin n_err++; $display("FAIL tmr_ack_width got %b exp 0", if1.timer_int_ack); end
        if1.timer_int = 1'b0;
        step(3);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL tmr_idle got %b exp 0", if1.int_req); end
    endtask

    task automatic test_simultaneous;
        if1.timer_int = 1'b1; if1.external_int = 1'b1;
        step(2);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd11) begin n_err++; $display("FAIL sim_ext_first got %b/%0d exp 1/11", if1.int_req, if1.int_cause); end
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack = 1'b0;
        n_vec++; if (if1.ext_int_ack !== 1'b1 || if1.timer_int_ack !== 1'b0) begin n_err++; $display("FAIL sim_ext_ack got e%b t%b exp e1 t0", if1.ext_int_ack, if1.timer_int_ack); end
        step(1);
        n_vec++; if (if1.ext_int_ack !== 1'b0) begin n_err++; $display("FAIL sim_ext_ack_end got %b exp 0", if1.ext_int_ack); end
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL sim_wait%0d got %b exp 0", i, if1.int_req); end
        end
        if1.external_int = 1'b0;
        step(1);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL sim_idle got %b exp 0", if1.int_req); end
        step(1);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL sim_timer_next got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        finish_if1();
    endtask

    task automatic test_ie_drop;
        if1.timer_int = 1'b1;
        step(2);
        n_vec++; if (if1.int_req !== 1'b1) begin n_err++; $display("FAIL ie_req got %b exp 1", if1.int_req); end
        if1.global_ie = 1'b0;
        step(1);
        n_vec++; if (if1.int_req !== 1'b0 || if1.int_cause !== 4'd0) begin n_err++; $display("FAIL ie_drop got %b/%0d exp 0/0", if1.int_req, if1.int_cause); end
        step(4);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL ie_off got %b exp 0", if1.int_req); end
        if1.global_ie = 1'b1;
        step(1);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL ie_rereq got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        finish_if1();
    endtask

    task automatic test_drop_timeout;
        if1.timer_int = 1'b1;
        step(2);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL to_req got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack = 1'b0;
        n_vec++; if (if1.timer_int_ack !== 1'b1) begin n_err++; $display("FAIL to_ack got %b exp 1", if1.timer_int_ack); end
        // New external edge lands while the timer is parked in the wait state.
        if1.external_int = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1);
            n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL to_wait%0d got %b exp 0", i, if1.int_req); end
        end
        step(1);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd11) begin n_err++; $display("FAIL to_ext_after got %b/%0d exp 1/11", if1.int_req, if1.int_cause); end
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack  = 1'b0;
        if1.external_int = 1'b0;
        n_vec++; if (if1.ext_int_ack !== 1'b1 || if1.timer_int_ack !== 1'b0) begin n_err++; $display("FAIL to_ext_ack got e%b t%b exp e1 t0", if1.ext_int_ack, if1.timer_int_ack); end
        for (int i = 0; i < 6; i++) begin
            step(1);
            n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL to_no_rereq%0d got %b exp 0", i, if1.int_req); end
        end
        if1.timer_int = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid_ack;
        if4.timer_int = 1'b1;
        step(2);
        n_vec++; if (if4.int_req !== 1'b1 || if4.int_cause !== 4'd7) begin n_err++; $display("FAIL rma_req got %b/%0d exp 1/7", if4.int_req, if4.int_cause); end
        if4.cpu_int_ack = 1'b1;
        step(1);
        if4.cpu_int_ack = 1'b0;
        step(1);
        n_vec++; if (if4.timer_int_ack !== 1'b1) begin n_err++; $display("FAIL rma_ack_on got %b exp 1", if4.timer_int_ack); end
        #3 reset = 1'b1;
        #1;
        n_vec++; if (if4.timer_int_ack !== 1'b0 || if4.int_req !== 1'b0 || if4.int_cause !== 4'd0) begin n_err++; $display("FAIL rma_async got ack%b req%b cause%0d exp 0/0/0", if4.timer_int_ack, if4.int_req, if4.int_cause); end
        step(1);
        reset = 1'b0;
        step(1);
        n_vec++; if (if4.int_req !== 1'b0) begin n_err++; $display("FAIL rma_lat1 got %b exp 0", if4.int_req); end
        step(1);
        n_vec++; if (if4.int_req !== 1'b1 || if4.int_cause !== 4'd7) begin n_err++; $display("FAIL rma_rereq got %b/%0d exp 1/7", if4.int_req, if4.int_cause); end
        if4.cpu_int_ack = 1'b1;
        step(1);
        if4.cpu_int_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (if4.timer_int_ack !== 1'b1) begin n_err++; $display("FAIL ack4_cyc%0d got %b exp 1", i, if4.timer_int_ack); end
            step(1);
        end
        n_vec++; if (if4.timer_int_ack !== 1'b0) begin n_err++; $display("FAIL ack4_end got %b exp 0", if4.timer_int_ack); end
        if4.timer_int = 1'b0;
        step(3);
    endtask

    task automatic test_ack_idle;
        if1.cpu_int_ack = 1'b1;
        step(1);
        if1.cpu_int_ack = 1'b0;
        n_vec++; if (if1.timer_int_ack !== 1'b0 || if1.ext_int_ack !== 1'b0 || if1.int_req !== 1'b0) begin n_err++; $display("FAIL idle_ack got t%b e%b r%b exp 000", if1.timer_int_ack, if1.ext_int_ack, if1.int_req); end
        if1.timer_int = 1'b1;
        step(1);
        n_vec++; if (if1.int_req !== 1'b0) begin n_err++; $display("FAIL idle_lat1 got %b exp 0", if1.int_req); end
        step(1);
        n_vec++; if (if1.int_req !== 1'b1 || if1.int_cause !== 4'd7) begin n_err++; $display("FAIL idle_still got %b/%0d exp 1/7", if1.int_req, if1.int_cause); end
        finish_if1();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        if1.timer_int = 1'b0; if1.external_int = 1'b0; if1.global_ie = 1'b0;
        if1.mie_timer = 1'b0; if1.mie_ext = 1'b0; if1.cpu_int_ack = 1'b0;
        if4.timer_int = 1'b0; if4.external_int = 1'b0; if4.global_ie = 1'b0;
        if4.mie_timer = 1'b0; if4.mie_ext = 1'b0; if4.cpu_int_ack = 1'b0;
        test_reset();
        test_timer_basic();
        test_simultaneous();
        test_ie_drop();
        test_drop_timeout();
        test_reset_mid_ack();
        test_ack_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
